pcie_tlp_master: RTL and testbench

- Requester-side counterpart of the PCIe TLP target on the 16-bit Lattice ECP3 PCIe core interface.
- Accepts single-DW memory read/write requests from a local master port and emits MRd/MWr TLPs (32- or 64-bit addressing) on the core's transmit interface.
- For reads, it monitors the shared receive stream for the matching CplD and returns the data to the local master.
- One request is outstanding at a time. The block sits beside the target on the same pcie_clk domain.

---
 rtl/pcie_tlp_pkg.sv | 44 ++++
 rtl/pcie_tlp_cpl_parser.sv | 70 +++++++
 rtl/pcie_tlp_master.sv | 203 ++++++++++++++++++++
 tb/tb_pcie_tlp_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// ============================================================================
// Module   : pcie_tlp_pkg
// Purpose  : Shared TLP encodings, completion word indices and master FSM
//            state encoding for the ECP3 16-bit PCIe requester/target pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_tlp_pkg;

  localparam logic [1:0] c_fmt_3dw_nodata = 2'b00;
  localparam logic [1:0] c_fmt_4dw_nodata = 2'b01;
  localparam logic [1:0] c_fmt_3dw_data   = 2'b10;
  localparam logic [1:0] c_fmt_4dw_data   = 2'b11;

  // MRd/MWr share the memory type; Cpl/CplD share the completion type
  localparam logic [4:0] c_type_mem = 5'b00000;
  localparam logic [4:0] c_type_cpl = 5'b01010;

  localparam logic [2:0] c_cpl_sc = 3'b000;
  localparam logic [2:0] c_cpl_ur = 3'b001;
  localparam logic [2:0] c_cpl_ca = 3'b100;

  localparam logic [3:0] c_rxw_hdr0    = 4'd0;
  localparam logic [3:0] c_rxw_hdr1    = 4'd1;
  localparam logic [3:0] c_rxw_cplid   = 4'd2;
  localparam logic [3:0] c_rxw_status  = 4'd3;
  localparam logic [3:0] c_rxw_reqid   = 4'd4;
  localparam logic [3:0] c_rxw_tag     = 4'd5;
  localparam logic [3:0] c_rxw_data_hi = 4'd6;
  localparam logic [3:0] c_rxw_data_lo = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_HDR      = 3'd2,
    ST_DATA     = 3'd3,
    ST_WAIT_CPL = 3'd4,
    ST_DONE     = 3'd5
  } mst_state_e;

endpackage

`default_nettype wire

// File: rtl/pcie_tlp_cpl_parser.sv
// ============================================================================
// Module   : pcie_tlp_cpl_parser
// Purpose  : Walks the shared rx word stream and extracts completion fields;
//            cpl_valid pulses for one cycle after the rx_end of a Cpl/CplD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_tlp_cpl_parser
  import pcie_tlp_pkg::*;
(
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  output logic        cpl_valid,
  output logic        cpl_hasdata,
  output logic [2:0]  cpl_status,
  output logic [15:0] cpl_reqid,
  output logic [7:0]  cpl_tag,
  output logic [31:0] cpl_data
);

  logic [3:0] r_idx;
  logic       r_inpkt;
  logic       r_is_cpl;
  logic       w_active;
  logic [3:0] w_idx;

  assign w_active = rx_st | r_inpkt;
  assign w_idx    = rx_st ? c_rxw_hdr0 : r_idx;

  always_ff @(posedge pcie_clk) begin
    if (!sys_rst_n) begin
      r_idx       <= 4'd0;
      r_inpkt     <= 1'b0;
      r_is_cpl    <= 1'b0;
      cpl_valid   <= 1'b0;
      cpl_hasdata <= 1'b0;
      cpl_status  <= 3'd0;
      cpl_reqid   <= 16'd0;
      cpl_tag     <= 8'd0;
      cpl_data    <= 32'd0;
    end else begin
      cpl_valid <= 1'b0;
      if (w_active) begin
        r_inpkt <= ~rx_end;
        r_idx   <= (w_idx == 4'hF) ? w_idx : w_idx + 4'd1;
        case (w_idx)
          c_rxw_hdr0: begin
            r_is_cpl    <= (rx_data[12:9] == c_type_cpl[4:1]);
            cpl_hasdata <= rx_data[14];
          end
          c_rxw_status:  cpl_status      <= rx_data[15:13];
          c_rxw_reqid:   cpl_reqid       <= rx_data;
          c_rxw_tag:     cpl_tag         <= rx_data[15:8];
          c_rxw_data_hi: cpl_data[31:16] <= rx_data;
          c_rxw_data_lo: cpl_data[15:0]  <= rx_data;
          default: ;
        endcase
        // a one-word packet can never be a completion
        if (rx_end) cpl_valid <= rx_st ? 1'b0 : r_is_cpl;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcie_tlp_master.sv
// ============================================================================
// Module   : pcie_tlp_master
// Purpose  : Single-DW MRd/MWr requester on the ECP3 16-bit tx/rx interface.
//            Optional completion timeout: define PCIE_TLP_MST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_tlp_master
  import pcie_tlp_pkg::*;
#(
  parameter logic [15:0] CPL_TIMEOUT = 16'hFFFF,
  parameter logic [7:0]  TAG_INIT    = 8'h00
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  input  logic        mst_req,
  input  logic        mst_we,
  input  logic [61:0] mst_adr,
  input  logic [3:0]  mst_be,
  input  logic [31:0] mst_dat_i,
  output logic [31:0] mst_dat_o,
  output logic        mst_ack,
  output logic        mst_err,
  output logic        busy
);

  mst_state_e  r_state;
  logic [7:0]  r_tag;
  logic [3:0]  r_wcnt;
  logic        r_we;
  logic [61:0] r_adr;
  logic [3:0]  r_be;
  logic [31:0] r_dat;
`ifdef PCIE_TLP_MST_TIMEOUT_EN
  logic [15:0] r_tocnt;
`endif

  logic        w_is64;
  logic [1:0]  w_fmt;
  logic [3:0]  w_hdr_len;
  logic [3:0]  w_len;
  logic [15:0] w_word;
  logic        w_cpl_valid;
  logic        w_cpl_hasdata;
  logic [2:0]  w_cpl_status;
  logic [15:0] w_cpl_reqid;
  logic [7:0]  w_cpl_tag;
  logic [31:0] w_cpl_data;
  logic        w_cpl_match;
  logic        w_cpl_good;

  pcie_tlp_cpl_parser u_cpl_parser (
    .pcie_clk    (pcie_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_st       (rx_st),
    .rx_end      (rx_end),
    .rx_data     (rx_data),
    .cpl_valid   (w_cpl_valid),
    .cpl_hasdata (w_cpl_hasdata),
    .cpl_status  (w_cpl_status),
    .cpl_reqid   (w_cpl_reqid),
    .cpl_tag     (w_cpl_tag),
    .cpl_data    (w_cpl_data)
  );

  // r_adr holds address bits [63:2]; bits [63:32] live in r_adr[61:30]
  assign w_is64    = |r_adr[61:30];
  assign w_fmt     = r_we ? (w_is64 ? c_fmt_4dw_data   : c_fmt_3dw_data)
                          : (w_is64 ? c_fmt_4dw_nodata : c_fmt_3dw_nodata);
  assign w_hdr_len = w_is64 ? 4'd8 : 4'd6;
  assign w_len     = w_hdr_len + (r_we ? 4'd2 : 4'd0);
  assign busy      = (r_state != ST_IDLE);

  assign w_cpl_match = w_cpl_valid && (w_cpl_reqid == {bus_num, dev_num, func_num})
                       && (w_cpl_tag == r_tag);
  assign w_cpl_good  = w_cpl_hasdata && (w_cpl_status == c_cpl_sc);

  always_comb begin
    w_word = 16'h0000;
    case (r_wcnt)
      4'd0: w_word = {1'b0, w_fmt, c_type_mem, 1'b0, 3'b000, 4'b0000};
      4'd1: w_word = 16'h0001;
      4'd2: w_word = {bus_num, dev_num, func_num};
      4'd3: w_word = {r_tag, 4'h0, r_be};
      4'd4: w_word = w_is64 ? r_adr[61:46] : r_adr[29:14];
      4'd5: w_word = w_is64 ? r_adr[45:30] : {r_adr[13:0], 2'b00};
      4'd6: w_word = w_is64 ? r_adr[29:14] : r_dat[31:16];
      4'd7: w_word = w_is64 ? {r_adr[13:0], 2'b00} : r_dat[15:0];
      4'd8: w_word = r_dat[31:16];
      4'd9: w_word = r_dat[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_tag     <= TAG_INIT;
      r_wcnt    <= 4'd0;
      r_we      <= 1'b0;
      r_adr     <= 62'd0;
      r_be      <= 4'd0;
      r_dat     <= 32'd0;
      tx_req    <= 1'b0;
      tx_st     <= 1'b0;
      tx_end    <= 1'b0;
      tx_data   <= 16'd0;
      mst_dat_o <= 32'd0;
      mst_ack   <= 1'b0;
      mst_err   <= 1'b0;
`ifdef PCIE_TLP_MST_TIMEOUT_EN
      r_tocnt   <= 16'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mst_req) begin
            r_we    <= mst_we;
            r_adr   <= mst_adr;
            r_be    <= mst_be;
            r_dat   <= mst_dat_i;
            r_wcnt  <= 4'd0;
            tx_req  <= 1'b1;
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (tx_rdy) begin
            tx_req  <= 1'b0;
            tx_st   <= 1'b1;
            tx_data <= w_word;
            r_wcnt  <= 4'd1;
            r_state <= ST_HDR;
          end
        end
        ST_HDR, ST_DATA: begin
          tx_st <= 1'b0;
          // r_wcnt is the index of the word being loaded this edge
          if (r_wcnt == w_len) begin
            tx_end  <= 1'b0;
            tx_data <= 16'd0;
            if (r_we) begin
              mst_ack <= 1'b1;
              mst_err <= 1'b0;
              r_state <= ST_DONE;
            end else begin
`ifdef PCIE_TLP_MST_TIMEOUT_EN
              r_tocnt <= 16'd0;
`endif
              r_state <= ST_WAIT_CPL;
            end
          end else begin
            tx_data <= w_word;
            tx_end  <= (r_wcnt == w_len - 4'd1);
            r_wcnt  <= r_wcnt + 4'd1;
            r_state <= (r_wcnt >= w_hdr_len) ? ST_DATA : ST_HDR;
          end
        end
        ST_WAIT_CPL: begin
          if (w_cpl_match) begin
            mst_ack   <= 1'b1;
            mst_err   <= ~w_cpl_good;
            mst_dat_o <= w_cpl_good ? w_cpl_data : 32'd0;
            r_tag     <= r_tag + 8'd1;
            r_state   <= ST_DONE;
          end
`ifdef PCIE_TLP_MST_TIMEOUT_EN
          else if (r_tocnt == CPL_TIMEOUT - 16'd1) begin
            mst_ack   <= 1'b1;
            mst_err   <= 1'b1;
            mst_dat_o <= 32'd0;
            r_tag     <= r_tag + 8'd1;
            r_state   <= ST_DONE;
          end else begin
            r_tocnt <= r_tocnt + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          mst_ack <= 1'b0;
          mst_err <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcie_tlp_master.sv
// ============================================================================
// Module   : tb_pcie_tlp_master
// Purpose  : Directed self-checking bench for pcie_tlp_master (TLP words,
//            completion handling, tag sequencing, timeout and reset abort).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_tlp_master;

  logic        pcie_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  bus_num  = 8'h3C;
  logic [4:0]  dev_num  = 5'h05;
  logic [2:0]  func_num = 3'h2;
  logic        tx_req, tx_rdy, tx_st, tx_end;
  logic [15:0] tx_data;
  logic        rx_st, rx_end;
  logic [15:0] rx_data;
  logic        mst_req, mst_we;
  logic [61:0] mst_adr;
  logic [3:0]  mst_be;
  logic [31:0] mst_dat_i, mst_dat_o;
  logic        mst_ack, mst_err, busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] ew [0:9];
  logic [15:0] rw [0:7];

  always #5 pcie_clk = ~pcie_clk;

  pcie_tlp_master #(.CPL_TIMEOUT(16'd100), .TAG_INIT(8'h00)) dut (
    .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n),
    .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
    .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
    .rx_st(rx_st), .rx_end(rx_end), .rx_data(rx_data),
    .mst_req(mst_req), .mst_we(mst_we), .mst_adr(mst_adr), .mst_be(mst_be),
    .mst_dat_i(mst_dat_i), .mst_dat_o(mst_dat_o), .mst_ack(mst_ack),
    .mst_err(mst_err), .busy(busy)
  );

  task automatic tick();
    @(negedge pcie_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [61:0] adr, input logic [3:0] be,
                       input logic [31:0] dat);
    mst_req = 1'b1; mst_we = we; mst_adr = adr; mst_be = be; mst_dat_i = dat;
    tick();
    chk("tx_req_raise", {31'd0, tx_req}, 32'd1);
    chk("busy_arb", {31'd0, busy}, 32'd1);
  endtask

  // grant three cycles after tx_req, then check every emitted word
  task automatic run_tlp(input string tag, input int n);
    repeat (2) tick();
    chk({tag, "_req_hold"}, {31'd0, tx_req}, 32'd1);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, tx_req}, 32'd0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), {16'd0, tx_data}, {16'd0, ew[i]});
      chk($sformatf("%s_st%0d", tag, i), {31'd0, tx_st}, {31'd0, (i == 0)});
      chk($sformatf("%s_end%0d", tag, i), {31'd0, tx_end}, {31'd0, (i == n - 1)});
      tick();
    end
    chk({tag, "_after"}, {30'd0, tx_st, tx_end}, 32'd0);
  endtask

  task automatic send_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rx_st = (i == 0); rx_end = (i == n - 1); rx_data = rw[i];
      tick();
    end
    rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'h0000;
  endtask

  task automatic wait_ack(input string tag, input int bound);
    int k = 0;
    while (mst_ack !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    chk({tag, "_ack"}, {31'd0, mst_ack}, 32'd1);
  endtask

  task automatic finish_ack(input string tag);
    mst_req = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, {30'd0, mst_ack, busy}, 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0; tx_rdy = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'h0;
    mst_req = 1'b0; mst_we = 1'b0; mst_adr = 62'd0; mst_be = 4'h0; mst_dat_i = 32'd0;
    repeat (3) tick();
    chk("rst_ctl", {26'd0, tx_req, tx_st, tx_end, mst_ack, mst_err, busy}, 32'd0);
    chk("rst_txd", {16'd0, tx_data}, 32'd0);
    chk("rst_dat", mst_dat_o, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // 32-bit write
    ew = '{16'h4000, 16'h0001, 16'h3C2A, 16'h000F, 16'h1000, 16'h0004,
           16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000};
    issue(1'b1, 62'h0000_0000_0400_0001, 4'hF, 32'hDEADBEEF);
    run_tlp("w32", 8);
    chk("w32_ack", {30'd0, mst_ack, mst_err}, 32'd2);
    finish_ack("w32");

    // 64-bit write
    ew = '{16'h6000, 16'h0001, 16'h3C2A, 16'h000F, 16'h0000, 16'h0001,
           16'h1000, 16'h0004, 16'hDEAD, 16'hBEEF};
    issue(1'b1, 62'h0000_0000_4400_0001, 4'hF, 32'hDEADBEEF);
    run_tlp("w64", 10);
    chk("w64_ack", {30'd0, mst_ack, mst_err}, 32'd2);
    finish_ack("w64");

    // read, tag 0, good CplD
    ew = '{16'h0000, 16'h0001, 16'h3C2A, 16'h000F, 16'h1000, 16'h0004,
           16'h0000, 16'h0000, 16'h0000, 16'h0000};
    issue(1'b0, 62'h0000_0000_0400_0001, 4'hF, 32'd0);
    run_tlp("rd0", 6);
    chk("rd0_wait", {30'd0, busy, mst_ack}, 32'd2);
    rw = '{16'h4A00, 16'h0001, 16'h0100, 16'h0004, 16'h3C2A, 16'h0004, 16'h1234, 16'h5678};
    send_rx(8);
    wait_ack("rd0", 4);
    chk("rd0_dat", mst_dat_o, 32'h12345678);
    chk("rd0_err", {31'd0, mst_err}, 32'd0);
    finish_ack("rd0");

    // read, tag 1: wrong-tag CplD ignored, then UR completion
    ew = '{16'h0000, 16'h0001, 16'h3C2A, 16'h0103, 16'h1000, 16'h0004,
           16'h0000, 16'h0000, 16'h0000, 16'h0000};
    issue(1'b0, 62'h0000_0000_0400_0001, 4'h3, 32'd0);
    run_tlp("rd1", 6);
    rw = '{16'h4A00, 16'h0001, 16'h0100, 16'h0004, 16'h3C2A, 16'h0504, 16'hCAFE, 16'hF00D};
    send_rx(8);
    repeat (6) tick();
    chk("mis_busy", {30'd0, busy, mst_ack}, 32'd2);
    chk("mis_dat_hold", mst_dat_o, 32'h12345678);
    rw = '{16'h0A00, 16'h0000, 16'h0100, 16'h2004, 16'h3C2A, 16'h0104, 16'h0000, 16'h0000};
    send_rx(6);
    wait_ack("ur", 4);
    chk("ur_err", {31'd0, mst_err}, 32'd1);
    chk("ur_dat", mst_dat_o, 32'd0);
    finish_ack("ur");

    // read, tag 2, no completion
    ew = '{16'h0000, 16'h0001, 16'h3C2A, 16'h020F, 16'h1000, 16'h0004,
           16'h0000, 16'h0000, 16'h0000, 16'h0000};
    issue(1'b0, 62'h0000_0000_0400_0001, 4'hF, 32'd0);
    run_tlp("rd2", 6);
`ifdef PCIE_TLP_MST_TIMEOUT_EN
    begin
      int k = 0;
      while (mst_ack !== 1'b1 && k < 200) begin
        tick();
        k++;
      end
      chk("to_cycles", k, 32'd100);
      chk("to_err", {31'd0, mst_err}, 32'd1);
      chk("to_dat", mst_dat_o, 32'd0);
      finish_ack("to");
    end
`else
    repeat (1000) tick();
    chk("noto_busy", {30'd0, busy, mst_ack}, 32'd2);
    mst_req = 1'b0;
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
`endif

    // reset during word 3 of a write
    issue(1'b1, 62'h0000_0000_0400_0001, 4'hF, 32'hDEADBEEF);
    repeat (2) tick();
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    repeat (3) tick();
    chk("mid_w3_st", {30'd0, tx_st, tx_end}, 32'd0);
    sys_rst_n = 1'b0;
    mst_req = 1'b0;
    tick();
    chk("mid_rst_ctl", {26'd0, tx_req, tx_st, tx_end, mst_ack, mst_err, busy}, 32'd0);
    chk("mid_rst_txd", {16'd0, tx_data}, 32'd0);
    chk("mid_rst_dat", mst_dat_o, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    chk("mid_no_end", {31'd0, tx_end}, 32'd0);

    // tag back at TAG_INIT and read works normally
    ew = '{16'h0000, 16'h0001, 16'h3C2A, 16'h000F, 16'h1000, 16'h0004,
           16'h0000, 16'h0000, 16'h0000, 16'h0000};
    issue(1'b0, 62'h0000_0000_0400_0001, 4'hF, 32'd0);
    run_tlp("prst", 6);
    rw = '{16'h4A00, 16'h0001, 16'h0100, 16'h0004, 16'h3C2A, 16'h0004, 16'hA5A5, 16'h5A5A};
    send_rx(8);
    wait_ack("prst", 4);
    chk("prst_dat", mst_dat_o, 32'hA5A55A5A);
    chk("prst_err", {31'd0, mst_err}, 32'd0);
    finish_ack("prst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
